cpu_mem_responder: RTL and testbench

//  Memory-side responder for the CPU data port: samples read_enable/write_enable

---
 rtl/cpu_mem_pkg.sv | 6 +
 rtl/cpu_mem_responder_if.sv | 18 +
 rtl/cpu_mem_sram.sv | 21 ++
 rtl/cpu_mem_responder.sv | 78 +++++++
 tb/tb_cpu_mem_responder.sv | 121 ++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared FSM state encoding, request op encoding and the wait-counter width.
package cpu_mem_pkg;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {BOOT, IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_NONE = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10, OP_WRRD = 2'b11} op_t;
endpackage

// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: CPU data-port request/ready bundle; master is the CPU, slave the responder.
interface cpu_mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] wdata_in;
    logic                  read_enable;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] rdata_out;
    logic                  cache_ready;
    logic                  busy;
    logic                  err_oob;
    modport master (output addr_in, wdata_in, read_enable, write_enable,
                    input  rdata_out, cache_ready, busy, err_oob);
    modport slave  (input  addr_in, wdata_in, read_enable, write_enable,
                    output rdata_out, cache_ready, busy, err_oob);
endinterface

// File: rtl/cpu_mem_sram.sv
// cpu_mem_sram: single-port synchronous RAM, registered read, write-first on the same address.
module cpu_mem_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            o_rdata       <= i_wdata;
        end else begin
            o_rdata <= r_mem[i_addr];
        end
    end
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: services CPU read/write requests from on-chip SRAM after LATENCY wait states,
// completing each with a single-cycle cache_ready pulse.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int LATENCY        = 2,
    parameter int BOOT_READY     = 1
) (
    input logic               clk,
    input logic               reset,
    cpu_mem_responder_if.slave bus
);
    state_t                    r_state, w_next;
    logic [CNT_W-1:0]          r_cnt;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    op_t                       r_op;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [DATA_WIDTH-1:0]     w_sram_q;
    logic [DATA_WIDTH-1:0]     w_resp_data;
    logic [MEM_DEPTH_LOG2-1:0] w_idx;
    logic                      w_req, w_oob, w_we, w_rd;

    assign w_req = bus.read_enable | bus.write_enable;
    assign w_oob = (r_addr >> MEM_DEPTH_LOG2) != '0;
    // From IDLE the read is issued straight off the bus so LATENCY=0 still has data in RESP.
    assign w_idx = (r_state == IDLE) ? bus.addr_in[MEM_DEPTH_LOG2-1:0] : r_addr[MEM_DEPTH_LOG2-1:0];
    assign w_we  = (r_state == RESP) && r_op[1] && !w_oob;
    assign w_rd  = (r_state == RESP) && r_op[0];
    assign w_resp_data = w_oob ? '0 : r_op[1] ? r_wdata : w_sram_q;

    cpu_mem_sram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(MEM_DEPTH_LOG2)) u_sram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_sram_q)
    );

    always_comb begin
        w_next          = r_state;
        bus.cache_ready = (r_state == RESP) || (r_state == BOOT && !reset);
        bus.busy        = (r_state == WAIT) || (r_state == RESP);
        bus.err_oob     = (r_state == RESP) && w_oob;
        bus.rdata_out   = w_rd ? w_resp_data : r_rdata;
        case (r_state)
            BOOT:    w_next = IDLE;
            IDLE:    w_next = w_req ? (LATENCY == 0 ? RESP : WAIT) : IDLE;
            WAIT:    w_next = (r_cnt == CNT_W'(1)) ? RESP : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= (BOOT_READY != 0) ? BOOT : IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_NONE;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_addr  <= bus.addr_in;
                r_wdata <= bus.wdata_in;
                r_op    <= op_t'({bus.write_enable, bus.read_enable});
                r_cnt   <= CNT_W'(LATENCY);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_rd) r_rdata <= w_resp_data;
        end
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed and random requests against a word-array memory model,
// plus a zero-latency instance driven by a CPU that re-requests on every ready.
module tb_cpu_mem_responder;
    logic clk = 0, reset = 1, reset0 = 1;
    int n_chk = 0, n_fail = 0;
    logic [31:0] mem [int];
    logic [31:0] hold = '0;
    always #5 clk = ~clk;

    cpu_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus (), bus0 ();
    cpu_mem_responder #(.LATENCY(2)) dut  (.clk(clk), .reset(reset),  .bus(bus.slave));
    cpu_mem_responder #(.LATENCY(0)) dut0 (.clk(clk), .reset(reset0), .bus(bus0.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [15:0] a, input logic [31:0] d, input logic re, input logic we, input string tag);
        logic oob;
        oob = (a >> 10) != 0;
        @(negedge clk);
        bus.addr_in = a; bus.wdata_in = d; bus.read_enable = re; bus.write_enable = we;
        @(posedge clk);
        #1;
        bus.read_enable = 0; bus.write_enable = 0;
        bus.addr_in = 16'($urandom); bus.wdata_in = $urandom;
        if (re) hold = oob ? 32'h0 : we ? d : mem[int'(a)];
        if (we && !oob) mem[int'(a)] = d;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            chk({tag, " ready"}, {31'b0, bus.cache_ready}, {31'b0, k == 2});
            if (k < 2) chk({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
        end
        chk({tag, " rdata"}, bus.rdata_out, hold);
        chk({tag, " err_oob"}, {31'b0, bus.err_oob}, {31'b0, oob});
        @(negedge clk);
        chk({tag, " ready drop"}, {31'b0, bus.cache_ready}, 32'd0);
        chk({tag, " idle busy"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, " rdata hold"}, bus.rdata_out, hold);
    endtask

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        logic re, we;
        bus.addr_in = 0; bus.wdata_in = 0; bus.read_enable = 0; bus.write_enable = 0;
        bus0.addr_in = 16'h0003; bus0.wdata_in = 32'hCAFEF00D; bus0.read_enable = 1; bus0.write_enable = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", {31'b0, bus.cache_ready}, 32'd0);
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        chk("reset rdata", bus.rdata_out, 32'd0);
        chk("reset ready0", {31'b0, bus0.cache_ready}, 32'd0);
        reset = 0;
        #1;
        chk("boot ready", {31'b0, bus.cache_ready}, 32'd1);
        chk("boot busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("boot ready drop", {31'b0, bus.cache_ready}, 32'd0);

        req(16'h0010, 32'hDEADBEEF, 0, 1, "wr10");
        req(16'h0010, 32'h0, 1, 0, "rd10");
        req(16'h0005, 32'h12345678, 1, 1, "wrrd5");
        req(16'h0005, 32'h0, 1, 0, "rd5");
        req(16'h0000, 32'h0BADF00D, 0, 1, "wr0");
        req(16'h0400, 32'h0, 1, 0, "rd400");
        req(16'h0400, 32'hFFFFFFFF, 0, 1, "wr400");
        req(16'h0000, 32'h0, 1, 0, "rd0 alias");

        req(16'h0020, 32'hAAAA5555, 0, 1, "wr20 old");
        @(negedge clk);
        bus.addr_in = 16'h0020; bus.wdata_in = 32'h11112222; bus.write_enable = 1;
        @(posedge clk);
        #1 bus.write_enable = 0;
        @(negedge clk);
        chk("abort busy", {31'b0, bus.busy}, 32'd1);
        reset = 1;
        hold = '0;
        #1;
        chk("abort ready", {31'b0, bus.cache_ready}, 32'd0);
        chk("abort busy rst", {31'b0, bus.busy}, 32'd0);
        chk("abort rdata", bus.rdata_out, 32'd0);
        @(negedge clk);
        chk("abort ready rst", {31'b0, bus.cache_ready}, 32'd0);
        reset = 0;
        #1 chk("reboot ready", {31'b0, bus.cache_ready}, 32'd1);
        req(16'h0020, 32'h0, 1, 0, "rd20 after abort");

        for (int i = 0; i < 40; i++) begin
            re = 1'($urandom); we = 1'($urandom);
            if (!re && !we) re = 1;
            case ($urandom_range(0, 4))
                0: a = 16'h0000;
                1: a = 16'h0005;
                2: a = 16'h03FF;
                3: a = 16'($urandom_range(1, 63)) << 10 | 16'($urandom_range(0, 1023));
                default: a = 16'($urandom_range(0, 1023));
            endcase
            if (re && !we && (a >> 10) == 0 && !mem.exists(int'(a))) we = 1;
            d = $urandom;
            req(a, d, re, we, $sformatf("rand%0d", i));
        end

        @(negedge clk);
        reset0 = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) #1;
            else @(negedge clk);
            chk($sformatf("lat0 ready%0d", i), {31'b0, bus0.cache_ready}, {31'b0, i % 2 == 0});
            if (i > 0) chk($sformatf("lat0 busy%0d", i), {31'b0, bus0.busy}, {31'b0, i % 2 == 0});
            if (i > 0 && i % 2 == 0) chk($sformatf("lat0 rdata%0d", i), bus0.rdata_out, 32'hCAFEF00D);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
